// File: rtl/wb_arbiter_rr.sv
// Round-robin N-master to 1-slave pipelined Wishbone arbiter with in-order ack routing via an ID FIFO.
// Optional macro WB_ARB_LOCK_EN adds m_lock, which keeps the pointer on a locking master.
module wb_arbiter_rr #(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_OUT   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_MASTERS-1:0]          m_stb,
    input  logic [N_MASTERS*AW-1:0]       m_adr,
    input  logic [N_MASTERS*(DW/8)-1:0]   m_sel,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*DW-1:0]       m_dat_w,
`ifdef WB_ARB_LOCK_EN
    input  logic [N_MASTERS-1:0]          m_lock,
`endif
    output logic [N_MASTERS-1:0]          m_stall,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [DW-1:0]                 m_dat_r,
    output logic                          s_stb,
    output logic [AW-1:0]                 s_adr,
    output logic [DW/8-1:0]               s_sel,
    output logic                          s_we,
    output logic [DW-1:0]                 s_dat_w,
    input  logic                          s_stall,
    input  logic                          s_ack,
    input  logic [DW-1:0]                 s_dat_r
);

    localparam int unsigned IW = $clog2(N_MASTERS);
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned SW = DW / 8;

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] fifo_q [MAX_OUT];
    logic [IW-1:0] fifo_d [MAX_OUT];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          gnt_valid;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] cand;
    logic [IW-1:0] gnt_next;
    logic          full;
    logic          accept;
    logic          ack_ok;

    // Scan from ptr upward, wrapping, and take the first requester.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = ptr_q;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!gnt_valid && m_stb[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
            cand = (cand == IW'(N_MASTERS - 1)) ? '0 : cand + 1'b1;
        end
        gnt_next = (gnt_idx == IW'(N_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    assign full   = (count_q == CW'(MAX_OUT));
    assign accept = s_stb && !s_stall;
    assign ack_ok = s_ack && (count_q != '0);

    always_comb begin
        s_stb   = rst_n && gnt_valid && !full;
        s_adr   = m_adr[gnt_idx*AW +: AW];
        s_sel   = m_sel[gnt_idx*SW +: SW];
        s_we    = m_we[gnt_idx];
        s_dat_w = m_dat_w[gnt_idx*DW +: DW];
        m_stall = '1;
        if (rst_n && gnt_valid) begin
            m_stall[gnt_idx] = s_stall || full;
        end
        m_ack   = '0;
        m_dat_r = '0;
        if (ack_ok) begin
            m_ack[fifo_q[rd_ptr_q]] = 1'b1;
            m_dat_r                 = s_dat_r;
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            fifo_d[wr_ptr_q] = gnt_idx;
            wr_ptr_d = (wr_ptr_q == PW'(MAX_OUT - 1)) ? '0 : wr_ptr_q + 1'b1;
`ifdef WB_ARB_LOCK_EN
            ptr_d = m_lock[gnt_idx] ? gnt_idx : gnt_next;
`else
            ptr_d = gnt_next;
`endif
        end
        if (ack_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(MAX_OUT - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (accept && !ack_ok) begin
            count_d = count_q + 1'b1;
        end else if (!accept && ack_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_OUT; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

`ifndef SYNTHESIS
    // A stray ack is dropped by the logic above; flag it so a misbehaving slave is visible.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(s_ack && count_q == '0))
            else $warning("wb_arbiter_rr: s_ack with no outstanding request dropped");
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: hand-computed vector table, reset/lock sequences, and random traffic
// checked against a queue-based model of the arbitration and ack-routing rules.
module tb_wb_arbiter_rr;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      m_stb, m_we, m_lock;
    logic [N*AW-1:0]   m_adr;
    logic [N*4-1:0]    m_sel;
    logic [N*DW-1:0]   m_dat_w;
    logic [N-1:0]      m_stall, m_ack;
    logic [DW-1:0]     m_dat_r, s_dat_w, s_dat_r;
    logic [AW-1:0]     s_adr;
    logic [3:0]        s_sel;
    logic              s_stb, s_we, s_stall, s_ack;

    int checks = 0;
    int errors = 0;

    // Model state: issue-order queue of master IDs and round-robin pointer.
    int q[$];
    int ptr = 0;

    always #5 clk = ~clk;

    wb_arbiter_rr #(.N_MASTERS(N), .AW(AW), .DW(DW), .MAX_OUT(MO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_stb   (m_stb),
        .m_adr   (m_adr),
        .m_sel   (m_sel),
        .m_we    (m_we),
        .m_dat_w (m_dat_w),
`ifdef WB_ARB_LOCK_EN
        .m_lock  (m_lock),
`endif
        .m_stall (m_stall),
        .m_ack   (m_ack),
        .m_dat_r (m_dat_r),
        .s_stb   (s_stb),
        .s_adr   (s_adr),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_dat_w (s_dat_w),
        .s_stall (s_stall),
        .s_ack   (s_ack),
        .s_dat_r (s_dat_r)
    );

    typedef struct {
        logic [1:0]  stb;
        logic        stall;
        logic        ack;
        logic [31:0] dat;
        logic        e_stb;
        logic [1:0]  e_stall;
        logic [1:0]  e_ack;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] stb, input logic stall, input logic ack,
                       input logic [31:0] dat, input logic e_stb, input logic [1:0] e_stall,
                       input logic [1:0] e_ack, input int e_cnt);
        vec_t v;
        v.stb = stb; v.stall = stall; v.ack = ack; v.dat = dat;
        v.e_stb = e_stb; v.e_stall = e_stall; v.e_ack = e_ack; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [1:0] stb, input logic stall, input logic ack,
                         input logic [31:0] dat, input logic [1:0] lock);
        m_stb = stb; s_stall = stall; s_ack = ack; s_dat_r = dat; m_lock = lock;
        m_adr = {$urandom, $urandom};
        m_dat_w = {$urandom, $urandom};
        m_sel = 8'($urandom);
        m_we = 2'($urandom);
        #1;
    endtask

    // Compare DUT outputs with the model for the inputs currently driven, then clock once.
    task automatic model_step();
        int g;
        int idx;
        bit full;
        logic e_stb;
        logic [1:0] e_stall, e_ack;
        logic [31:0] e_dat;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (g < 0 && m_stb[idx]) g = idx;
        end
        full = (q.size() == MO);
        e_stb = (g >= 0) && !full;
        e_stall = 2'b11;
        if (g >= 0) e_stall[g] = s_stall || full;
        e_ack = 2'b00;
        e_dat = '0;
        if (s_ack && q.size() > 0) begin
            e_ack[q[0]] = 1'b1;
            e_dat = s_dat_r;
        end
        chk("s_stb", s_stb, e_stb);
        chk("m_stall", m_stall, e_stall);
        chk("m_ack", m_ack, e_ack);
        chk("m_dat_r", m_dat_r, e_dat);
        if (g >= 0) begin
            chk("s_adr", s_adr, m_adr[g*AW +: AW]);
            chk("s_dat_w", s_dat_w, m_dat_w[g*DW +: DW]);
            chk("s_sel", s_sel, m_sel[g*4 +: 4]);
            chk("s_we", s_we, m_we[g]);
        end
        if (s_ack && q.size() > 0) void'(q.pop_front());
        if (e_stb && !s_stall) begin
            q.push_back(g);
`ifdef WB_ARB_LOCK_EN
            ptr = m_lock[g] ? g : (g + 1) % N;
`else
            ptr = (g + 1) % N;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        ptr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        m_stb = '0; m_we = '0; m_lock = '0; m_adr = '0; m_sel = '0; m_dat_w = '0;
        s_stall = 1'b0; s_ack = 1'b0; s_dat_r = '0;
        repeat (3) @(posedge clk);
        #1;
        // Outputs must be quiet during reset even with requests and an ack present.
        drive(2'b11, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b00);
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_m_stall", m_stall, 2'b11);
        chk("rst_m_ack", m_ack, 2'b00);
        chk("rst_m_dat_r", m_dat_r, 32'h0);
        chk("rst_count", dut.count_q, 0);
        rst_n = 1'b1;

        add(2'b00, 0, 0, 32'h0,  0, 2'b11, 2'b00, 0);
        add(2'b11, 0, 0, 32'h0,  1, 2'b10, 2'b00, 0);
        add(2'b11, 0, 1, 32'hA0, 1, 2'b01, 2'b01, 1);
        add(2'b11, 0, 1, 32'hA1, 1, 2'b10, 2'b10, 1);
        add(2'b11, 0, 1, 32'hA2, 1, 2'b01, 2'b01, 1);
        add(2'b00, 0, 1, 32'hA3, 0, 2'b11, 2'b10, 1);
        add(2'b01, 0, 0, 32'h0,  1, 2'b10, 2'b00, 0);
        add(2'b01, 0, 0, 32'h0,  1, 2'b10, 2'b00, 1);
        add(2'b01, 0, 0, 32'h0,  1, 2'b10, 2'b00, 2);
        add(2'b01, 0, 0, 32'h0,  1, 2'b10, 2'b00, 3);
        add(2'b01, 0, 0, 32'h0,  0, 2'b11, 2'b00, 4);
        add(2'b01, 0, 1, 32'hB0, 0, 2'b11, 2'b01, 4);
        add(2'b01, 0, 0, 32'h0,  1, 2'b10, 2'b00, 3);
        add(2'b00, 0, 1, 32'hB1, 0, 2'b11, 2'b01, 4);
        add(2'b00, 0, 1, 32'hB2, 0, 2'b11, 2'b01, 3);
        add(2'b10, 0, 1, 32'hB3, 1, 2'b01, 2'b01, 2);
        add(2'b00, 0, 1, 32'hB4, 0, 2'b11, 2'b01, 2);
        add(2'b00, 0, 1, 32'hB5, 0, 2'b11, 2'b10, 1);
        add(2'b00, 0, 1, 32'hB6, 0, 2'b11, 2'b00, 0);
        add(2'b00, 0, 0, 32'h0,  0, 2'b11, 2'b00, 0);
        add(2'b01, 1, 0, 32'h0,  1, 2'b11, 2'b00, 0);
        add(2'b11, 1, 0, 32'h0,  1, 2'b11, 2'b00, 0);
        add(2'b11, 0, 0, 32'h0,  1, 2'b10, 2'b00, 0);
        add(2'b10, 0, 1, 32'hC0, 1, 2'b01, 2'b01, 1);
        add(2'b00, 0, 1, 32'hC1, 0, 2'b11, 2'b10, 1);

        foreach (tbl[i]) begin
            drive(tbl[i].stb, tbl[i].stall, tbl[i].ack, tbl[i].dat, 2'b00);
            chk($sformatf("v%0d_s_stb", i), s_stb, tbl[i].e_stb);
            chk($sformatf("v%0d_m_stall", i), m_stall, tbl[i].e_stall);
            chk($sformatf("v%0d_m_ack", i), m_ack, tbl[i].e_ack);
            chk($sformatf("v%0d_m_dat_r", i), m_dat_r, (tbl[i].e_ack != 2'b00) ? tbl[i].dat : 32'h0);
            chk($sformatf("v%0d_count", i), dut.count_q, tbl[i].e_cnt);
            model_step();
        end

        // Reset in the middle of traffic with three requests outstanding.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'b01, 1'b0, 1'b0, 32'h0, 2'b00);
            model_step();
        end
        chk("mid_count_before", dut.count_q, 3);
        drive(2'b01, 1'b0, 1'b1, 32'h5555_AAAA, 2'b00);
        #2;
        rst_n = 1'b0;
        q.delete();
        ptr = 0;
        #1;
        chk("mid_rst_count", dut.count_q, 0);
        chk("mid_rst_ptr", dut.ptr_q, 0);
        chk("mid_rst_s_stb", s_stb, 1'b0);
        chk("mid_rst_m_stall", m_stall, 2'b11);
        chk("mid_rst_m_ack", m_ack, 2'b00);
        chk("mid_rst_m_dat_r", m_dat_r, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'b00, 1'b0, 1'b1, 32'h1234_5678, 2'b00);
        chk("late_ack_dropped", m_ack, 2'b00);
        model_step();
        chk("late_ack_count", dut.count_q, 0);

`ifdef WB_ARB_LOCK_EN
        do_reset();
        drive(2'b01, 1'b0, 1'b0, 32'h0, 2'b00);
        model_step();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 1'b0, 1'b1, 32'h0, 2'b10);
            chk($sformatf("lock%0d_m_stall", i), m_stall, 2'b01);
            model_step();
        end
        drive(2'b11, 1'b0, 1'b1, 32'h0, 2'b00);
        chk("unlock_m_stall", m_stall, 2'b01);
        model_step();
        drive(2'b11, 1'b0, 1'b1, 32'h0, 2'b00);
        chk("after_unlock_m_stall", m_stall, 2'b10);
        model_step();
`endif

        // Random traffic; acks are only issued when the model has something outstanding.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(2'($urandom), ($urandom_range(0, 3) == 0), (q.size() > 0) && $urandom_range(0, 1) == 1,
                  $urandom, 2'($urandom));
            model_step();
            if (i % 50 == 0) chk("rand_count", dut.count_q, q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
